// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and baud-timing helpers (used by uart_rx/uart_tx)
//  Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchronizer with configurable reset value
//  Revision    : 1.0
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver; define UART_RX_PARITY_EN for 8E1 with parity_err
//  Revision    : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             rxs;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             tick;
    logic             cnt_run;
`ifdef UART_RX_PARITY_EN
    logic             pbad_q, pbad_d;
    logic             perr_q, perr_d;
`endif

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    // Sample tick: mid-start after half a bit, then once per full bit period.
    always_comb begin
        tick    = 1'b0;
        cnt_run = 1'b0;
        case (state_q)
            START: begin
                cnt_run = 1'b1;
                tick    = (cnt_q == HALF_LAST);
            end
            DATA, PARITY, STOP: begin
                cnt_run = 1'b1;
                tick    = (cnt_q == BIT_LAST);
            end
            default: begin
                cnt_run = 1'b0;
                tick    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                if (tick) state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (cnt_run && !tick) ? cnt_q + 1'b1 : '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) bit_d = 3'd0;
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q != 3'd7) bit_d = bit_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) pbad_d = rxs ^ (^shift_q);
            end
`endif
            STOP: begin
                // Byte and flags are published together, even for a bad frame.
                if (tick) begin
                    data_d = shift_q;
                    done_d = 1'b1;
                    ferr_d = !rxs;
`ifdef UART_RX_PARITY_EN
                    perr_d = pbad_q;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire
